// File: rtl/puck_mover_n.sv
// Air-hockey puck physics: scans N_PAD paddles for collisions each movement tick, then
// moves the puck with wall reflection, periodic friction and goal detection.
module puck_mover_n #(
   parameter int XW         = 10,
   parameter int VW         = 5,
   parameter int N_PAD      = 2,
   parameter int R2         = 700,
   parameter int VMAX       = 15,
   parameter int X_LO       = 234,
   parameter int X_HI       = 694,
   parameter int Y_LO       = 111,
   parameter int Y_HI       = 431,
   parameter int G_YLO      = 246,
   parameter int G_YHI      = 296,
   parameter int CX         = 464,
   parameter int CY         = 271,
   parameter int FRIC_TICKS = 8,
   parameter int HOLD_TICKS = 60,
   parameter int SERVE_V    = 4
) (
   input  logic                    clk,
   input  logic                    clr,
   input  logic                    tick,
   input  logic [N_PAD*XW-1:0]     pad_x,
   input  logic [N_PAD*XW-1:0]     pad_y,
   output logic [XW-1:0]           dot_x,
   output logic [XW-1:0]           dot_y,
   output logic signed [VW-1:0]    vel_x,
   output logic signed [VW-1:0]    vel_y,
   output logic                    goal_l,
   output logic                    goal_r,
   output logic                    busy
);

   localparam int KW  = (N_PAD > 1) ? $clog2(N_PAD) : 1;
   localparam int FW  = $clog2(FRIC_TICKS + 1);
   localparam int HW  = $clog2(HOLD_TICKS + 1);
   localparam int SW  = VW + XW;
   localparam int D2W = 2 * XW + 2;

   localparam logic [D2W-1:0]       R2_T    = D2W'(R2);
   localparam logic signed [SW-1:0] SAT_HI  = SW'(VMAX);
   localparam logic signed [SW-1:0] SAT_LO  = -(SW'(VMAX));
   localparam logic signed [VW-1:0] V_HI    = VW'(VMAX);
   localparam logic signed [VW-1:0] V_LO    = -(VW'(VMAX));
   localparam logic signed [VW-1:0] V_SERVE = VW'(SERVE_V);
   localparam logic signed [VW-1:0] V_ONE   = VW'(1);
   localparam logic signed [VW-1:0] V_ZERO  = '0;
   localparam logic signed [XW+1:0] NX_LO   = (XW+2)'(X_LO);
   localparam logic signed [XW+1:0] NX_HI   = (XW+2)'(X_HI);
   localparam logic signed [XW+1:0] NY_LO   = (XW+2)'(Y_LO);
   localparam logic signed [XW+1:0] NY_HI   = (XW+2)'(Y_HI);
   localparam logic [XW-1:0]        XLO_T   = XW'(X_LO);
   localparam logic [XW-1:0]        XHI_T   = XW'(X_HI);
   localparam logic [XW-1:0]        YLO_T   = XW'(Y_LO);
   localparam logic [XW-1:0]        YHI_T   = XW'(Y_HI);
   localparam logic [XW-1:0]        GLO_T   = XW'(G_YLO);
   localparam logic [XW-1:0]        GHI_T   = XW'(G_YHI);
   localparam logic [XW-1:0]        CX_T    = XW'(CX);
   localparam logic [XW-1:0]        CY_T    = XW'(CY);

   typedef enum logic [1:0] {IDLE, SCAN, MOVE, HOLD} state_t;

   state_t         state;
   logic [KW-1:0]  k;
   logic           hit_done;
   logic [FW-1:0]  fric_cnt;
   logic [HW-1:0]  hold_cnt;
   logic           serve_pos;

   logic [XW-1:0]        cur_px, cur_py;
   logic signed [XW:0]   dx, dy;
   logic [XW:0]          adx, ady;
   logic [D2W-1:0]       d2;
   logic signed [VW-1:0] hit_vx, hit_vy;

   logic signed [XW+1:0] nx, ny;
   logic                 in_win, go_l, go_r, fric_hit;
   logic [XW-1:0]        mv_x, mv_y;
   logic signed [VW-1:0] mv_vx, mv_vy, fr_vx, fr_vy;

   // Velocity plus paddle offset, computed wide so a large offset clamps instead of wrapping.
   function automatic logic signed [VW-1:0] sat_add(input logic signed [VW-1:0] v,
                                                    input logic signed [XW:0]   d);
      logic signed [SW-1:0] s;
      s = SW'(v) + SW'(d);
      if (s > SAT_HI)
         return V_HI;
      else if (s < SAT_LO)
         return V_LO;
      else
         return $signed(s[VW-1:0]);
   endfunction

   function automatic logic signed [VW-1:0] step0(input logic signed [VW-1:0] v);
      if (v > V_ZERO)
         return v - V_ONE;
      else if (v < V_ZERO)
         return v + V_ONE;
      else
         return v;
   endfunction

   always_comb begin
      cur_px = pad_x[int'(k)*XW +: XW];
      cur_py = pad_y[int'(k)*XW +: XW];
      dx     = $signed({1'b0, dot_x}) - $signed({1'b0, cur_px});
      dy     = $signed({1'b0, dot_y}) - $signed({1'b0, cur_py});
      adx    = dx[XW] ? $unsigned(-dx) : $unsigned(dx);
      ady    = dy[XW] ? $unsigned(-dy) : $unsigned(dy);
      d2     = D2W'(adx) * D2W'(adx) + D2W'(ady) * D2W'(ady);
      hit_vx = sat_add(vel_x, dx);
      hit_vy = sat_add(vel_y, dy);
   end

   // Goal test uses the pre-move y so the mouth window matches where the puck crossed.
   always_comb begin
      nx       = $signed({2'b00, dot_x}) + (XW+2)'(vel_x);
      ny       = $signed({2'b00, dot_y}) + (XW+2)'(vel_y);
      in_win   = (dot_y >= GLO_T) && (dot_y <= GHI_T);
      go_l     = (nx < NX_LO) && in_win;
      go_r     = (nx > NX_HI) && in_win;
      fric_hit = (fric_cnt == FW'(FRIC_TICKS - 1));

      mv_x  = nx[XW-1:0];
      mv_vx = vel_x;
      if (nx < NX_LO) begin
         mv_x  = XLO_T;
         mv_vx = -vel_x;
      end else if (nx > NX_HI) begin
         mv_x  = XHI_T;
         mv_vx = -vel_x;
      end

      mv_y  = ny[XW-1:0];
      mv_vy = vel_y;
      if (ny < NY_LO) begin
         mv_y  = YLO_T;
         mv_vy = -vel_y;
      end else if (ny > NY_HI) begin
         mv_y  = YHI_T;
         mv_vy = -vel_y;
      end

      fr_vx = fric_hit ? step0(mv_vx) : mv_vx;
      fr_vy = fric_hit ? step0(mv_vy) : mv_vy;
   end

   always_ff @(posedge clk) begin
      if (clr) begin
         state     <= IDLE;
         dot_x     <= CX_T;
         dot_y     <= CY_T;
         vel_x     <= VW'(7);
         vel_y     <= VW'(3);
         goal_l    <= 1'b0;
         goal_r    <= 1'b0;
         busy      <= 1'b0;
         k         <= '0;
         hit_done  <= 1'b0;
         fric_cnt  <= '0;
         hold_cnt  <= '0;
         serve_pos <= 1'b0;
      end else begin
         goal_l <= 1'b0;
         goal_r <= 1'b0;
         case (state)
            IDLE: begin
               if (tick) begin
                  state    <= SCAN;
                  busy     <= 1'b1;
                  k        <= '0;
                  hit_done <= 1'b0;
               end
            end
            SCAN: begin
               if (!hit_done && (d2 <= R2_T)) begin
                  vel_x    <= hit_vx;
                  vel_y    <= hit_vy;
                  hit_done <= 1'b1;
               end
               if (k == KW'(N_PAD - 1))
                  state <= MOVE;
               else
                  k <= k + 1'b1;
            end
            MOVE: begin
               busy     <= 1'b0;
               fric_cnt <= fric_hit ? '0 : fric_cnt + 1'b1;
               if (go_l || go_r) begin
                  goal_l    <= go_l;
                  goal_r    <= go_r;
                  dot_x     <= CX_T;
                  dot_y     <= CY_T;
                  vel_x     <= V_ZERO;
                  vel_y     <= V_ZERO;
                  hold_cnt  <= '0;
                  serve_pos <= go_l;
                  state     <= HOLD;
               end else begin
                  dot_x <= mv_x;
                  dot_y <= mv_y;
                  vel_x <= fr_vx;
                  vel_y <= fr_vy;
                  state <= IDLE;
               end
            end
            HOLD: begin
               if (tick) begin
                  if (hold_cnt == HW'(HOLD_TICKS - 1)) begin
                     hold_cnt <= '0;
                     vel_x    <= serve_pos ? V_SERVE : -V_SERVE;
                     vel_y    <= V_ZERO;
                     state    <= IDLE;
                  end else begin
                     hold_cnt <= hold_cnt + 1'b1;
                  end
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_puck_mover_n.sv
// Bench for puck_mover_n: hand-checked vector table, goal/hold/serve sequences, random
// paddle play and a mid-scan reset, all scored against a behavioural puck model.
module tb_puck_mover_n;

   localparam int XW = 10;
   localparam int VW = 5;
   localparam int N_PAD = 2;

   logic                 clk = 1'b0;
   logic                 clr;
   logic                 tick;
   logic [N_PAD*XW-1:0]  pad_x, pad_y;
   logic [XW-1:0]        dot_x, dot_y;
   logic signed [VW-1:0] vel_x, vel_y;
   logic                 goal_l, goal_r, busy;

   int n_cmp = 0;
   int n_bad = 0;

   puck_mover_n dut (
      .clk(clk), .clr(clr), .tick(tick), .pad_x(pad_x), .pad_y(pad_y),
      .dot_x(dot_x), .dot_y(dot_y), .vel_x(vel_x), .vel_y(vel_y),
      .goal_l(goal_l), .goal_r(goal_r), .busy(busy)
   );

   always #5 clk = ~clk;

   typedef struct {
      int p0x, p0y, p1x, p1y;
      int ex, ey, evx, evy;
   } vec_t;

   typedef struct {
      int x, y, vx, vy, gl, gr, bmask, mx, my;
   } exp_t;

   exp_t sb_q[$];
   vec_t vecs[9];

   int m_x, m_y, m_vx, m_vy, m_fric, m_hold, m_holding, m_serve;
   int busy_mask, mid_x, mid_y;

   function automatic int sat(input int v);
      if (v > 15) return 15;
      if (v < -15) return -15;
      return v;
   endfunction

   function automatic int toward0(input int v);
      if (v > 0) return v - 1;
      if (v < 0) return v + 1;
      return 0;
   endfunction

   task automatic check(input string name, input int act, input int req);
      n_cmp++;
      if (act != req) begin
         n_bad++;
         $display("[TB] FAIL %s: got %0d, expected %0d", name, act, req);
      end
   endtask

   task automatic model_reset();
      m_x = 464; m_y = 271; m_vx = 7; m_vy = 3;
      m_fric = 0; m_hold = 0; m_holding = 0; m_serve = 0;
   endtask

   task automatic model_tick(input int px0, input int py0, input int px1, input int py1);
      exp_t e;
      int px[2], py[2];
      int dx, dy, nx, ny;
      bit hit, win, fric_now;
      px[0] = px0; py[0] = py0; px[1] = px1; py[1] = py1;
      e.mx = m_x; e.my = m_y; e.gl = 0; e.gr = 0;
      if (m_holding != 0) begin
         e.bmask = 0;
         m_hold++;
         if (m_hold == 60) begin
            m_holding = 0; m_hold = 0; m_vx = m_serve; m_vy = 0;
         end
      end else begin
         e.bmask = 7;
         hit = 0;
         for (int p = 0; p < 2; p++) begin
            dx = m_x - px[p];
            dy = m_y - py[p];
            if (!hit && (dx*dx + dy*dy <= 700)) begin
               hit = 1;
               m_vx = sat(m_vx + dx);
               m_vy = sat(m_vy + dy);
            end
         end
         nx = m_x + m_vx;
         ny = m_y + m_vy;
         win = (m_y >= 246) && (m_y <= 296);
         fric_now = (m_fric == 7);
         m_fric = fric_now ? 0 : m_fric + 1;
         if (nx < 234 && win) e.gl = 1;
         else if (nx > 694 && win) e.gr = 1;
         if (e.gl != 0 || e.gr != 0) begin
            m_x = 464; m_y = 271; m_vx = 0; m_vy = 0;
            m_holding = 1; m_hold = 0;
            m_serve = (e.gl != 0) ? 4 : -4;
         end else begin
            if (nx < 234) begin m_x = 234; m_vx = -m_vx; end
            else if (nx > 694) begin m_x = 694; m_vx = -m_vx; end
            else m_x = nx;
            if (ny < 111) begin m_y = 111; m_vy = -m_vy; end
            else if (ny > 431) begin m_y = 431; m_vy = -m_vy; end
            else m_y = ny;
            if (fric_now) begin
               m_vx = toward0(m_vx);
               m_vy = toward0(m_vy);
            end
         end
      end
      e.x = m_x; e.y = m_y; e.vx = m_vx; e.vy = m_vy;
      sb_q.push_back(e);
   endtask

   // Called at a negedge; leaves the bench at the negedge after the MOVE edge.
   task automatic applyStimulus(input int p0x, input int p0y, input int p1x, input int p1y,
                                input int tick_len);
      pad_x = {10'(p1x), 10'(p0x)};
      pad_y = {10'(p1y), 10'(p0y)};
      tick  = 1'b1;
      model_tick(p0x, p0y, p1x, p1y);
      busy_mask = 0;
      for (int c = 0; c < 4; c++) begin
         @(posedge clk);
         @(negedge clk);
         if (c == tick_len - 1) tick = 1'b0;
         if (c < 3 && busy === 1'b1) busy_mask |= (1 << c);
         if (c == 2) begin
            mid_x = int'(dot_x);
            mid_y = int'(dot_y);
         end
      end
   endtask

   task automatic checkOutput(input string tag);
      exp_t e;
      if (sb_q.size() == 0) begin
         n_cmp++; n_bad++;
         $display("[TB] FAIL %s.scoreboard: got empty queue, expected an entry", tag);
         return;
      end
      e = sb_q.pop_front();
      check({tag, ".dot_x"}, int'(dot_x), e.x);
      check({tag, ".dot_y"}, int'(dot_y), e.y);
      check({tag, ".vel_x"}, int'(vel_x), e.vx);
      check({tag, ".vel_y"}, int'(vel_y), e.vy);
      check({tag, ".goal_l"}, int'(goal_l), e.gl);
      check({tag, ".goal_r"}, int'(goal_r), e.gr);
      check({tag, ".busy_seq"}, busy_mask, e.bmask);
      check({tag, ".busy_end"}, int'(busy), 0);
      check({tag, ".mid_x"}, mid_x, e.mx);
      check({tag, ".mid_y"}, mid_y, e.my);
   endtask

   initial begin
      #2000000;
      $display("[TB] FAIL watchdog: got timeout, expected completion");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      bit found;
      int ox, oy;

      vecs[0] = '{0,   0,   0,   0,   471, 274,  7,  3};
      vecs[1] = '{481, 284, 476, 279, 468, 267, -3, -7};
      vecs[2] = '{448, 260, 0,   0,   483, 267, 15,  0};
      vecs[3] = '{463, 267, 0,   0,   498, 267, 15,  0};
      vecs[4] = '{518, 267, 0,   0,   493, 267, -5,  0};
      vecs[5] = '{518, 267, 0,   0,   478, 267, -15, 0};
      vecs[6] = '{452, 262, 0,   0,   463, 267, -15, 0};
      vecs[7] = '{450, 244, 0,   0,   461, 282, -1, 14};
      vecs[8] = '{0,   0,   461, 292, 460, 286, -1,  4};

      clr = 1'b1; tick = 1'b0; pad_x = '0; pad_y = '0;
      repeat (2) @(negedge clk);
      check("rst.dot_x", int'(dot_x), 464);
      check("rst.dot_y", int'(dot_y), 271);
      check("rst.vel_x", int'(vel_x), 7);
      check("rst.vel_y", int'(vel_y), 3);
      check("rst.goal_l", int'(goal_l), 0);
      check("rst.goal_r", int'(goal_r), 0);
      check("rst.busy", int'(busy), 0);
      clr = 1'b0;
      model_reset();

      for (int i = 0; i < 9; i++) begin
         applyStimulus(vecs[i].p0x, vecs[i].p0y, vecs[i].p1x, vecs[i].p1y, (i == 0) ? 4 : 1);
         checkOutput($sformatf("vec%0d", i));
         check($sformatf("vec%0d.tbl_x", i), int'(dot_x), vecs[i].ex);
         check($sformatf("vec%0d.tbl_y", i), int'(dot_y), vecs[i].ey);
         check($sformatf("vec%0d.tbl_vx", i), int'(vel_x), vecs[i].evx);
         check($sformatf("vec%0d.tbl_vy", i), int'(vel_y), vecs[i].evy);
         if (i == 0) begin
            repeat (3) @(negedge clk);
            check("drop.dot_x", int'(dot_x), 471);
            check("drop.busy", int'(busy), 0);
         end
      end

      // Left goal, hold and serve
      applyStimulus(474, 290, 0, 0, 1);
      checkOutput("aim_l");
      check("aim_l.vel_x", int'(vel_x), -15);
      found = 0;
      for (int i = 0; i < 40 && !found; i++) begin
         applyStimulus(0, 0, 0, 0, 1);
         if (sb_q[$].gl != 0) found = 1;
         checkOutput($sformatf("run_l%0d", i));
      end
      if (!found) begin
         n_cmp++; n_bad++;
         $display("[TB] FAIL goal_l_reach: got no goal, expected goal_l within 40 ticks");
      end else begin
         check("goal_l.pulse", int'(goal_l), 1);
         check("goal_l.cx", int'(dot_x), 464);
         check("goal_l.cy", int'(dot_y), 271);
         check("goal_l.vx", int'(vel_x), 0);
         @(negedge clk);
         check("goal_l.width", int'(goal_l), 0);
         check("goal_l.other", int'(goal_r), 0);
      end
      for (int i = 0; i < 60; i++) begin
         applyStimulus(474, 281, 0, 0, 1);
         checkOutput($sformatf("hold_l%0d", i));
      end
      check("serve_l.vel_x", int'(vel_x), 4);
      check("serve_l.vel_y", int'(vel_y), 0);

      // Right goal, hold and serve
      applyStimulus(453, 271, 0, 0, 1);
      checkOutput("aim_r");
      found = 0;
      for (int i = 0; i < 40 && !found; i++) begin
         applyStimulus(0, 0, 0, 0, 1);
         if (sb_q[$].gr != 0) found = 1;
         checkOutput($sformatf("run_r%0d", i));
      end
      if (!found) begin
         n_cmp++; n_bad++;
         $display("[TB] FAIL goal_r_reach: got no goal, expected goal_r within 40 ticks");
      end else begin
         check("goal_r.pulse", int'(goal_r), 1);
         check("goal_r.other", int'(goal_l), 0);
      end
      for (int i = 0; i < 60; i++) begin
         applyStimulus(0, 0, 0, 0, 1);
         checkOutput($sformatf("hold_r%0d", i));
      end
      check("serve_r.vel_x", int'(vel_x), -4);

      // Diagonal run into the y wall and then the right wall outside the goal mouth
      applyStimulus(445, 256, 0, 0, 1);
      checkOutput("aim_w");
      check("aim_w.vel_x", int'(vel_x), 15);
      check("aim_w.vel_y", int'(vel_y), 15);
      for (int i = 0; i < 30; i++) begin
         applyStimulus(0, 0, 0, 0, 1);
         checkOutput($sformatf("wall%0d", i));
      end

      // Random paddle play
      for (int i = 0; i < 150; i++) begin
         int a0x, a0y, a1x, a1y;
         a0x = 0; a0y = 0; a1x = 1000; a1y = 1000;
         if ($urandom_range(0, 1) == 1) begin
            ox = int'($urandom_range(0, 40)) - 20;
            oy = int'($urandom_range(0, 40)) - 20;
            a0x = m_x + ox; a0y = m_y + oy;
         end
         if ($urandom_range(0, 2) == 0) begin
            ox = int'($urandom_range(0, 40)) - 20;
            oy = int'($urandom_range(0, 40)) - 20;
            a1x = m_x + ox; a1y = m_y + oy;
         end
         applyStimulus(a0x, a0y, a1x, a1y, 1);
         checkOutput($sformatf("rnd%0d", i));
      end

      // Reset during the second scan cycle discards the scan
      clr = 1'b1;
      @(negedge clk);
      clr = 1'b0;
      model_reset();
      pad_x = {10'd0, 10'd474};
      pad_y = {10'd0, 10'd281};
      tick = 1'b1;
      @(posedge clk); @(negedge clk);
      tick = 1'b0;
      @(posedge clk); @(negedge clk);
      clr = 1'b1;
      @(posedge clk); @(negedge clk);
      check("midclr.dot_x", int'(dot_x), 464);
      check("midclr.dot_y", int'(dot_y), 271);
      check("midclr.vel_x", int'(vel_x), 7);
      check("midclr.vel_y", int'(vel_y), 3);
      check("midclr.busy", int'(busy), 0);
      clr = 1'b0;
      repeat (3) @(negedge clk);
      check("midclr.idle_x", int'(dot_x), 464);
      check("midclr.idle_busy", int'(busy), 0);
      applyStimulus(0, 0, 0, 0, 1);
      checkOutput("post_clr");
      check("post_clr.tbl_x", int'(dot_x), 471);
      check("post_clr.tbl_y", int'(dot_y), 274);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
